// File: rtl/ql_pp3_mult_pipe.sv
// Pipelined, parametrised front-end for the pp3 32x32 hard multiplier with valid/ready backpressure.
// Define QL_MULT_ACC_EN to add a wrap-around accumulator at the final stage.
module ql_pp3_mult_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 32,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic                 acc_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
);

  // Stages after the operand stage; with LATENCY=1 the single stage is the output stage.
  localparam int TAIL = (LATENCY > 1) ? LATENCY - 1 : 1;

  // A 33rd bit keeps a 32-bit unsigned operand positive in the signed multiply.
  function automatic logic signed [32:0] ext_a(input logic [A_WIDTH-1:0] v, input logic sgn);
    return {{(33 - A_WIDTH){sgn & v[A_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [32:0] ext_b(input logic [B_WIDTH-1:0] v, input logic sgn);
    return {{(33 - B_WIDTH){sgn & v[B_WIDTH-1]}}, v};
  endfunction

  function automatic logic [63:0] mult_ext(input logic signed [32:0] x, input logic signed [32:0] y);
    logic signed [63:0] xw;
    logic signed [63:0] yw;
    xw = {{31{x[32]}}, x};
    yw = {{31{y[32]}}, y};
    return xw * yw;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] acc_wrap(input logic [OUT_WIDTH-1:0] acc,
                                                    input logic                 restart,
                                                    input logic [OUT_WIDTH-1:0] term);
    logic [OUT_WIDTH-1:0] base;
    base = restart ? '0 : acc;
    return base + term;
  endfunction

  logic stall;
  logic take;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign take     = in_valid && in_ready;

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;

  assign a_ext = ext_a(a, a_signed);
  assign b_ext = ext_b(b, b_signed);

  logic                 term_vld;
  logic                 term_first;
  logic [63:0]          term_prod;
  logic [OUT_WIDTH-1:0] term_lo;

  generate
    if (LATENCY > 1) begin : g_op_stage
      logic               vld_p1;
      logic               first_p1;
      logic signed [32:0] a_p1;
      logic signed [32:0] b_p1;

      // Stage 1: extended operands and mode bits
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1 <= 1'b0;
        end else if (!stall) begin
          vld_p1 <= take;
        end
      end

      always_ff @(posedge clk) begin
        if (!stall) begin
          a_p1     <= a_ext;
          b_p1     <= b_ext;
          first_p1 <= acc_first;
        end
      end

      assign term_vld   = vld_p1;
      assign term_first = first_p1;
      assign term_prod  = mult_ext(a_p1, b_p1);
    end else begin : g_no_op_stage
      assign term_vld   = take;
      assign term_first = acc_first;
      assign term_prod  = mult_ext(a_ext, b_ext);
    end

    if (OUT_WIDTH < 64) begin : g_prod_hi
      logic [63-OUT_WIDTH:0] unused_prod_hi;
      assign unused_prod_hi = term_prod[63:OUT_WIDTH];
    end
  endgenerate

  assign term_lo = term_prod[OUT_WIDTH-1:0];

  // Tail index k holds pipeline stage k+2 (k+1 when LATENCY=1); the last entry is the output stage.
  logic [TAIL-1:0]      vld_pn;
  logic [TAIL-1:0]      first_pn;
  logic [OUT_WIDTH-1:0] data_pn [TAIL];

  logic [TAIL-1:0]      v_in;
  logic [TAIL-1:0]      f_in;
  logic [OUT_WIDTH-1:0] d_in [TAIL];
  logic [OUT_WIDTH-1:0] final_val;

  always_comb begin
    v_in    = '0;
    f_in    = '0;
    v_in[0] = term_vld;
    f_in[0] = term_first;
    d_in[0] = term_lo;
    for (int k = 1; k < TAIL; k++) begin
      v_in[k] = vld_pn[k-1];
      f_in[k] = first_pn[k-1];
      d_in[k] = data_pn[k-1];
    end
  end

`ifdef QL_MULT_ACC_EN
  // The output register doubles as the accumulator: it only loads on valid beats.
  assign final_val = acc_wrap(data_pn[TAIL-1], f_in[TAIL-1], d_in[TAIL-1]);
`else
  logic unused_first;
  assign unused_first = f_in[TAIL-1];
  assign final_val    = d_in[TAIL-1];
`endif

  // Tail stages: product lane through to the output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pn <= '0;
    end else if (!stall) begin
      vld_pn <= v_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      first_pn <= f_in;
      for (int k = 0; k < TAIL - 1; k++) begin
        data_pn[k] <= d_in[k];
      end
    end
    if (rst) begin
      data_pn[TAIL-1] <= '0;
    end else if (!stall && v_in[TAIL-1]) begin
      data_pn[TAIL-1] <= final_val;
    end
  end

  logic unused_tail_first;
  assign unused_tail_first = first_pn[TAIL-1];

  assign out_valid = vld_pn[TAIL-1];
  assign out_data  = data_pn[TAIL-1];

endmodule

// File: tb/tb_ql_pp3_mult_pipe.sv
// Directed self-checking bench for ql_pp3_mult_pipe: a 16x16->32 instance (LATENCY=2)
// and a 32x32->64 instance (LATENCY=3).
module tb_ql_pp3_mult_pipe;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, a_signed, b_signed, acc_first, out_valid, out_ready;
  logic [15:0] a, b;
  logic [31:0] out_data;

  logic        in_valid1, in_ready1, a_signed1, b_signed1, acc_first1, out_valid1, out_ready1;
  logic [31:0] a1, b1;
  logic [63:0] out_data1;

  int errors = 0;
  int checks = 0;

  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic        sf [8];
  logic [31:0] se [8];

  ql_pp3_mult_pipe dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_first(acc_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  ql_pp3_mult_pipe #(.A_WIDTH(32), .B_WIDTH(32), .OUT_WIDTH(64), .LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .a_signed(a_signed1), .b_signed(b_signed1), .acc_first(acc_first1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated beat on dut0: valid exactly two edges after it is offered, for one cycle.
  task automatic beat0(input logic [15:0] av, input logic [15:0] bv, input logic as, input logic bs,
                       input logic [31:0] exp, input string tag);
    a = av; b = bv; a_signed = as; b_signed = bs; acc_first = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({tag, " valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, " data"}, {32'd0, out_data}, {32'd0, exp});
    @(posedge clk); #1;
    chk({tag, " one-cycle"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic beat1(input logic [31:0] av, input logic [31:0] bv, input logic as, input logic bs,
                       input logic [63:0] exp, input string tag);
    a1 = av; b1 = bv; a_signed1 = as; b_signed1 = bs; acc_first1 = 1'b1;
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk({tag, " early"}, {63'd0, out_valid1}, 64'd0);
    @(posedge clk); #1;
    chk({tag, " valid"}, {63'd0, out_valid1}, 64'd1);
    chk({tag, " data"}, out_data1, exp);
  endtask

  // Streams n beats from sa/sb/sf into dut0, out_ready low during cycles st_lo..st_hi.
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input logic sgn,
                            input string tag, output int stalls);
    int          sent, got;
    logic        held_vld, accepted;
    logic [31:0] held;
    sent = 0; got = 0; stalls = 0; held_vld = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (sent < n);
      if (sent < n) begin
        a = sa[sent]; b = sb[sent]; acc_first = sf[sent];
        a_signed = sgn; b_signed = sgn;
      end
      #1;
      chk({tag, " in_ready"}, {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (out_valid && !out_ready) begin
        stalls++;
        if (held_vld) chk({tag, " hold"}, {32'd0, out_data}, {32'd0, held});
        held = out_data; held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk({tag, " data"}, {32'd0, out_data}, (got < n) ? {32'd0, se[got]} : 64'hx);
        got++;
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, " count"}, 64'(got), 64'(n));
  endtask

  initial begin
    int   st;
    logic stale;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; acc_first = 1'b0;
    out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; a_signed1 = 1'b0; b_signed1 = 1'b0; acc_first1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_data", {32'd0, out_data}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid1", {63'd0, out_valid1}, 64'd0);
    rst = 1'b0;

    beat0(16'hFFFF, 16'h0002, 1'b1, 1'b1, 32'hFFFFFFFE, "ss");
    beat0(16'hFFFF, 16'h0002, 1'b0, 1'b0, 32'h0001FFFE, "uu");
    beat0(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001, "su");

    beat1(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, "w ss");
    beat1(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, "w uu");
    beat1(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h8000000080000000, "w su");

    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'(i); sb[i] = 16'd3; sf[i] = 1'b0; se[i] = 32'(3 * i);
    end
    run_stream(8, 3, 5, 1'b0, "stream", st);
    chk("stream stalls", 64'(st), 64'd3);

    sa[0] = 16'd2; sb[0] = 16'd3; sf[0] = 1'b1;
    sa[1] = 16'd4; sb[1] = 16'd5; sf[1] = 1'b0;
    sa[2] = 16'd1; sb[2] = 16'd1; sf[2] = 1'b1;
`ifdef QL_MULT_ACC_EN
    se[0] = 32'd6; se[1] = 32'd26; se[2] = 32'd1;
`else
    se[0] = 32'd6; se[1] = 32'd20; se[2] = 32'd1;
`endif
    run_stream(3, -1, -1, 1'b0, "acc", st);

    a = 16'd7; b = 16'd7; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'd9; b = 16'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst out_data", {32'd0, out_data}, 64'd0);
    rst = 1'b0;
    stale = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    chk("midrst no stale", {63'd0, stale}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
